// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// IF/ID pipeline register between the I-cache fetch port and the decode
// stage. It takes {pc, instr} from fetch with a valid/ready handshake. The
// I-cache can miss, so fetch may present nothing for several cycles. The
// stage holds the current instruction while decode is stalled. It kills
// everything it holds when a branch/jump redirect flushes the pipe.
//
// With SKID_EN=1 a one-entry skid buffer absorbs the instruction that fetch
// hands over in the same cycle that decode stalls. This lets if_ready come
// straight from a flop, so the hazard unit's stall never has a combinational
// path back into the I-cache. With SKID_EN=0 there is no skid buffer, and
// if_ready is computed combinationally from id_valid and stall.
//
// The decoded raw fields and the five RV32I immediates are pure wiring off
// the registered instruction. They add no latency.
//
// Parameters
//   NOP_INSTR  instruction driven on id_instr whenever id_valid is low
//   RESET_PC   value of id_pc after reset
//   SKID_EN    1: skid buffer, registered if_ready; 0: no skid buffer
//
// Ports
//   clock      in   1   rising-edge clock
//   reset      in   1   synchronous, active-high
//   if_valid   in   1   fetch presents a valid {if_pc, if_instr}
//   if_ready   out  1   stage can accept (transfer on if_valid && if_ready)
//   if_pc      in   32  PC of the fetched instruction
//   if_instr   in   32  fetched instruction word
//   stall      in   1   decode cannot consume id_* this cycle
//   flush      in   1   redirect: kill held and incoming instructions
//   id_valid   out  1   id_* carries a live instruction
//   id_pc      out  32  registered PC
//   id_instr   out  32  registered instruction (NOP_INSTR when !id_valid)
//   id_opcode  out  7   instr[6:0]
//   id_rd      out  5   instr[11:7]
//   id_funct3  out  3   instr[14:12]
//   id_rs1     out  5   instr[19:15]
//   id_rs2     out  5   instr[24:20]
//   id_funct7  out  7   instr[31:25]
//   id_imm_i   out  32  I-type immediate, sign-extended
//   id_imm_s   out  32  S-type immediate, sign-extended
//   id_imm_b   out  32  B-type immediate, sign-extended
//   id_imm_u   out  32  U-type immediate
//   id_imm_j   out  32  J-type immediate, sign-extended
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          SKID_EN   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,

    input  logic        stall,
    input  logic        flush,

    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,

    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_funct3,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [6:0]  id_funct7,

    output logic [31:0] id_imm_i,
    output logic [31:0] id_imm_s,
    output logic [31:0] id_imm_b,
    output logic [31:0] id_imm_u,
    output logic [31:0] id_imm_j
);

    // Main (decode-facing) register
    logic        id_valid_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_instr_q;

    // Skid entry. It always holds an instruction that is younger than the
    // one in the main register, and older than anything fetch is offering.
    logic        skid_valid_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_instr_q;

    logic        accept;
    logic        consume;
    logic        main_open;
    logic        skid_write;

    assign accept    = if_valid && if_ready;
    assign consume   = id_valid_q && !stall;

    // The main register can take a new instruction this cycle.
    assign main_open = !id_valid_q || consume;

    // An accepted instruction can only land in the skid while the main
    // register is held by a stall. With SKID_EN=0, if_ready is already low
    // in that situation, so the gate on SKID_EN is a second safeguard.
    assign skid_write = SKID_EN && accept && !main_open && !flush;

    // Ready generation. With the skid buffer, "room for one more" is exactly
    // "skid empty". That is purely a flop output, so stall does not reach
    // if_ready in the same cycle.
    generate
        if (SKID_EN) begin : g_ready_skid
            assign if_ready = !skid_valid_q;
        end else begin : g_ready_comb
            assign if_ready = !id_valid_q || !stall;
        end
    endgenerate

    // Main register update. Flush has priority over everything except reset.
    // The PC is held on flush and on drain, so id_pc keeps showing the last
    // real instruction rather than a stale input.
    // The skid entry has priority over the input so that program order is
    // kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= RESET_PC;
            id_instr_q <= NOP_INSTR;
        end else if (flush) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
        end else if (main_open) begin
            if (skid_valid_q) begin
                id_valid_q <= 1'b1;
                id_pc_q    <= skid_pc_q;
                id_instr_q <= skid_instr_q;
            end else if (accept) begin
                id_valid_q <= 1'b1;
                id_pc_q    <= if_pc;
                id_instr_q <= if_instr;
            end else begin
                id_valid_q <= 1'b0;
                id_instr_q <= NOP_INSTR;
            end
        end
    end

    // Skid update. Whenever the main register opens, a full skid drains
    // into it, so the skid always empties in that case. It fills only when
    // an instruction arrives while main is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_pc_q    <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
        end else if (flush || main_open) begin
            skid_valid_q <= 1'b0;
        end else if (skid_write) begin
            skid_valid_q <= 1'b1;
            skid_pc_q    <= if_pc;
            skid_instr_q <= if_instr;
        end
    end

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;

    // Raw instruction fields
    assign id_opcode = id_instr_q[6:0];
    assign id_rd     = id_instr_q[11:7];
    assign id_funct3 = id_instr_q[14:12];
    assign id_rs1    = id_instr_q[19:15];
    assign id_rs2    = id_instr_q[24:20];
    assign id_funct7 = id_instr_q[31:25];

    // RV32I immediates. The B and J forms scatter their bits and always have
    // an implicit zero LSB.
    assign id_imm_i = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
    assign id_imm_s = {{20{id_instr_q[31]}}, id_instr_q[31:25], id_instr_q[11:7]};
    assign id_imm_b = {{19{id_instr_q[31]}}, id_instr_q[31], id_instr_q[7],
                       id_instr_q[30:25], id_instr_q[11:8], 1'b0};
    assign id_imm_u = {id_instr_q[31:12], 12'b0};
    assign id_imm_j = {{11{id_instr_q[31]}}, id_instr_q[31], id_instr_q[19:12],
                       id_instr_q[20], id_instr_q[30:21], 1'b0};

endmodule
